// File: rtl/adc_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_sequencer
// Description : Arms on a host start pulse, waits for an immediate or
//               rising-edge trigger, then captures N sample pairs from the
//               dual-channel ADC driver and forwards each pair as one
//               Avalon-ST beat with ready/valid backpressure.
//               Optional decimation is enabled by defining ADC_SEQ_DECIM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_sequencer #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DEC_W  = 8
) (
  input  logic                CLK_65,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic                trig_mode,
  input  logic                trig_in,
  input  logic [CNT_W-1:0]    n_samples,
`ifdef ADC_SEQ_DECIM_EN
  input  logic [DEC_W-1:0]    decim,
`endif
  output logic                adc_enable,
  input  logic [DATA_W-1:0]   adc_a,
  input  logic [DATA_W-1:0]   adc_b,
  input  logic                adc_valid,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sop,
  output logic                out_eop,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  // Zero-width configurations are meaningless; stop elaboration early.
  generate
    if (DATA_W == 0 || CNT_W == 0 || DEC_W == 0) begin : g_bad_params
      $error("adc_capture_sequencer: DATA_W, CNT_W and DEC_W must be non-zero");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CNT_W-1:0]    r_n;         // latched burst length
  logic [CNT_W-1:0]    r_cnt;       // beats loaded so far in this burst
  logic                r_mode;      // latched trigger mode
  logic                r_trig_q;    // previous trig_in for edge detect
  logic [2*DATA_W-1:0] r_data;
  logic                r_out_valid;
  logic                r_sop;
  logic                r_eop;
  logic                r_done;
  logic                r_overrun;

  logic                w_accept;
  logic                w_trig_edge;
  logic                w_keep;
  logic                w_room;
  logic                w_load;
  logic                w_drop;
  logic                w_pop;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_last;

  // r_cnt < r_n always holds in CAPTURE, so the increment cannot wrap.
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_last      = (w_cnt_inc == r_n);
  assign w_accept    = (r_state == ST_IDLE) && start && (n_samples != '0) && !abort;
  assign w_trig_edge = trig_in && !r_trig_q;
  // The output register can take a new beat if it is empty or being popped now.
  assign w_room      = !r_out_valid || out_ready;
  assign w_load      = (r_state == ST_CAPTURE) && w_keep && w_room;
  assign w_drop      = (r_state == ST_CAPTURE) && w_keep && !w_room;
  assign w_pop       = r_out_valid && out_ready;

`ifdef ADC_SEQ_DECIM_EN
  logic [DEC_W-1:0] r_decim;
  logic [DEC_W-1:0] r_dcnt;

  assign w_keep = adc_valid && (r_dcnt == '0);

  // Modulo-(decim+1) sample counter, restarted each time CAPTURE is entered.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      r_decim <= '0;
      r_dcnt  <= '0;
    end else begin
      if (w_accept) begin
        r_decim <= decim;
      end
      if (r_state != ST_CAPTURE && w_state_nxt == ST_CAPTURE) begin
        r_dcnt <= '0;
      end else if (r_state == ST_CAPTURE && adc_valid) begin
        r_dcnt <= (r_dcnt == r_decim) ? '0 : r_dcnt + 1'b1;
      end
    end
  end
`else
  assign w_keep = adc_valid;
`endif

  // State register.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and ADC enable; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    adc_enable  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        adc_enable = 1'b1;
        if (!r_mode || w_trig_edge) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        adc_enable = 1'b1;
        if (w_load && w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pop) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort) w_state_nxt = ST_IDLE;
  end

  // Burst configuration, beat counter, output register and status flags.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      r_n         <= '0;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_trig_q    <= 1'b0;
      r_data      <= '0;
      r_out_valid <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_trig_q <= trig_in;
      r_done   <= 1'b0;
      if (abort) begin
        r_out_valid <= 1'b0;
        r_sop       <= 1'b0;
        r_eop       <= 1'b0;
        r_cnt       <= '0;
      end else begin
        if (w_accept) begin
          r_n       <= n_samples;
          r_mode    <= trig_mode;
          r_overrun <= 1'b0;
          r_cnt     <= '0;
        end
        if (w_load) begin
          r_out_valid <= 1'b1;
          r_data      <= {adc_b, adc_a};
          r_sop       <= (r_cnt == '0);
          r_eop       <= w_last;
          r_cnt       <= w_cnt_inc;
        end else if (w_pop) begin
          r_out_valid <= 1'b0;
          r_sop       <= 1'b0;
          r_eop       <= 1'b0;
        end
        if (w_drop) begin
          r_overrun <= 1'b1;
        end
        if (r_state == ST_DRAIN && w_pop) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_out_valid;
  assign out_sop   = r_sop;
  assign out_eop   = r_eop;
  assign done      = r_done;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
